// File: rtl/fetch_pair_unit.sv
// -----------------------------------------------------------------------------
// fetch_pair_unit
//
// Front-end fetch stage sitting directly upstream of the dual-entry
// instruction FIFO. Holds the fetch PC, issues one aligned 64-bit request at a
// time to the I-cache, and splits each response into one or two
// {instruction, PC} writes on the FIFO's two write ports. Redirects discard
// any in-flight response; fifo_full only blocks new requests.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   redirect_en, redirect_pc  branch/exception redirect and its target PC
//   fifo_full                 FIFO full flag, suppresses new requests
//   inst_req, inst_addr       I-cache request valid / 8-byte aligned address
//   inst_addr_ok              cache accepted the request this cycle
//   inst_data_ok, inst_rdata  response valid / 64-bit response data
//   write_en1/2, write_data1/2, write_address1/2
//                             FIFO write ports (port 2 only with port 1)
//   fetch_pc                  current fetch PC (debug)
//
// Optional build macro: FETCH_PERF_COUNTERS_EN
//   When defined, adds internal 64-bit counters req_count_q (accepted
//   requests) and drop_count_q (discarded responses). No ports are added.
// -----------------------------------------------------------------------------
module fetch_pair_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        fifo_full,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [63:0] inst_rdata,
  output logic        write_en1,
  output logic [31:0] write_data1,
  output logic [31:0] write_address1,
  output logic        write_en2,
  output logic [31:0] write_data2,
  output logic [31:0] write_address2,
  output logic [31:0] fetch_pc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;

  assign inst_addr = {pc_q[31:3], 3'b000};
  assign fetch_pc  = pc_q;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    req_pc_d       = req_pc_q;
    write_en1      = 1'b0;
    write_data1    = 32'd0;
    write_address1 = 32'd0;
    write_en2      = 1'b0;
    write_data2    = 32'd0;
    write_address2 = 32'd0;

    inst_req = (state_q == S_IDLE) && !fifo_full && !redirect_en && !rst;

    // Redirect retargets the PC regardless of state; the state transitions
    // below decide what happens to any outstanding response.
    if (redirect_en) begin
      pc_d = redirect_pc;
    end

    case (state_q)
      S_IDLE: begin
        if (inst_req && inst_addr_ok) begin
          req_pc_d = pc_q;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_en) begin
          // A response arriving with the redirect is simply dropped;
          // otherwise remember to discard it when it shows up.
          state_d = inst_data_ok ? S_IDLE : S_DROP;
        end else if (inst_data_ok && !rst) begin
          write_en1      = 1'b1;
          write_address1 = req_pc_q;
          if (!req_pc_q[2]) begin
            // Even word: both halves of the 64-bit line are valid.
            write_data1    = inst_rdata[31:0];
            write_en2      = 1'b1;
            write_data2    = inst_rdata[63:32];
            write_address2 = req_pc_q + 32'd4;
            pc_d           = req_pc_q + 32'd8;
          end else begin
            // Odd word: only the upper half belongs to this fetch.
            write_data1 = inst_rdata[63:32];
            pc_d        = req_pc_q + 32'd4;
          end
          state_d = S_IDLE;
        end
      end
      S_DROP: begin
        if (inst_data_ok) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  logic [63:0] req_count_q, req_count_d;
  logic [63:0] drop_count_q, drop_count_d;

  always_comb begin
    req_count_d  = req_count_q;
    drop_count_d = drop_count_q;
    if (inst_req && inst_addr_ok) begin
      req_count_d = req_count_q + 64'd1;
    end
    if (inst_data_ok && ((state_q == S_DROP) || ((state_q == S_WAIT) && redirect_en))) begin
      drop_count_d = drop_count_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_count_q  <= 64'd0;
      drop_count_q <= 64'd0;
    end else begin
      req_count_q  <= req_count_d;
      drop_count_q <= drop_count_d;
    end
  end
`endif

endmodule
